// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, ALU operation
// codes, FSM state encoding and the registered control bundle.
package cpu_ctrl_pkg;

    localparam int OP_LOADI = 0;
    localparam int OP_MOV   = 1;
    localparam int OP_ADD   = 2;
    localparam int OP_SUB   = 3;
    localparam int OP_AND   = 4;
    localparam int OP_OR    = 5;
    localparam int OP_J     = 6;
    localparam int OP_BEQ   = 7;
    localparam int OP_LWD   = 8;
    localparam int OP_LWI   = 9;
    localparam int OP_SWD   = 10;
    localparam int OP_SWI   = 11;
    localparam int OP_MULT  = 12;
    localparam int OP_SLL   = 13;
    localparam int OP_SRA   = 14;
    localparam int OP_ROR   = 15;
    localparam int OP_BNE   = 16;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRA = 3'b110;
    localparam logic [2:0] ALU_ROR = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_TRAP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] aluop;
        logic       write_enable;
        logic       sub_mux_sel;
        logic       imm_mux_sel;
        logic       jump;
        logic       beq;
        logic       bne;
        logic       read;
        logic       write;
        logic       write_sel;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Combinational opcode decoder: opcode -> control bundle plus illegal flag.
// Extended opcodes decode only when EXT_OPS is non-zero.
module ctrl_decode_comb
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int EXT_OPS  = 1
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl,
    output logic                illegal
);

    logic is_ext;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ctrl    = '0;
        illegal = 1'b0;
        is_ext  = 1'b0;
        case (int'(opcode))
            OP_LOADI: begin ctrl.aluop = ALU_FWD; ctrl.write_enable = 1'b1; ctrl.imm_mux_sel = 1'b1; end
            OP_MOV:   begin ctrl.aluop = ALU_FWD; ctrl.write_enable = 1'b1; end
            OP_ADD:   begin ctrl.aluop = ALU_ADD; ctrl.write_enable = 1'b1; end
            OP_SUB:   begin ctrl.aluop = ALU_ADD; ctrl.write_enable = 1'b1; ctrl.sub_mux_sel = 1'b1; end
            OP_AND:   begin ctrl.aluop = ALU_AND; ctrl.write_enable = 1'b1; end
            OP_OR:    begin ctrl.aluop = ALU_OR;  ctrl.write_enable = 1'b1; end
            OP_J:     begin ctrl.aluop = ALU_FWD; ctrl.jump = 1'b1; end
            OP_BEQ:   begin ctrl.aluop = ALU_ADD; ctrl.sub_mux_sel = 1'b1; ctrl.beq = 1'b1; end
            OP_LWD:   begin ctrl.aluop = ALU_FWD; ctrl.write_enable = 1'b1; ctrl.read = 1'b1; ctrl.write_sel = 1'b1; end
            OP_LWI:   begin
                ctrl.aluop        = ALU_FWD;
                ctrl.write_enable = 1'b1;
                ctrl.imm_mux_sel  = 1'b1;
                ctrl.read         = 1'b1;
                ctrl.write_sel    = 1'b1;
            end
            OP_SWD:   begin ctrl.aluop = ALU_FWD; ctrl.write = 1'b1; end
            OP_SWI:   begin ctrl.aluop = ALU_FWD; ctrl.imm_mux_sel = 1'b1; ctrl.write = 1'b1; end
            OP_MULT:  begin is_ext = 1'b1; ctrl.aluop = ALU_MUL; ctrl.write_enable = 1'b1; end
            OP_SLL:   begin is_ext = 1'b1; ctrl.aluop = ALU_SLL; ctrl.write_enable = 1'b1; end
            OP_SRA:   begin is_ext = 1'b1; ctrl.aluop = ALU_SRA; ctrl.write_enable = 1'b1; end
            OP_ROR:   begin is_ext = 1'b1; ctrl.aluop = ALU_ROR; ctrl.write_enable = 1'b1; end
            OP_BNE:   begin is_ext = 1'b1; ctrl.aluop = ALU_ADD; ctrl.sub_mux_sel = 1'b1; ctrl.bne = 1'b1; end
            default:  illegal = 1'b1;
        endcase
        // Without the extension the extended opcodes are plain illegal opcodes.
        if (is_ext && (EXT_OPS == 0)) begin
            ctrl    = '0;
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/control_unit_pipelined.sv
// Registered control unit: one-stage pipeline register with stall hold,
// branch flush, sticky illegal-opcode trap and retired-instruction counter.
module control_unit_pipelined
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_W  = 32,
    parameter int OPCODE_W = 8,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 16,
    parameter int EXT_OPS  = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [INSTR_W-1:0] INSTRUCTION,
    input  logic               INSTR_VALID,
    input  logic               MEM_BUSYWAIT,
    input  logic               FLUSH,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic               WRITEENABLE,
    output logic               SUBMUXSEL,
    output logic               IMMUXSEL,
    output logic               JUMP,
    output logic               BEQ,
    output logic               BNE,
    output logic               READ,
    output logic               WRITE,
    output logic               WRITESEL,
    output logic               CTRL_VALID,
    output logic               PC_HOLD,
    output logic               ILLEGAL,
    output logic [CNT_W-1:0]   INSTR_COUNT
);

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             valid_q, valid_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;

    ctrl_t dec_ctrl;
    logic  dec_illegal;
    logic  unused_operands;

    assign unused_operands = ^INSTRUCTION[INSTR_W-OPCODE_W-1:0];

    ctrl_decode_comb #(
        .OPCODE_W (OPCODE_W),
        .EXT_OPS  (EXT_OPS)
    ) u_decode (
        .opcode  (INSTRUCTION[INSTR_W-1 -: OPCODE_W]),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        if (state_q == ST_TRAP) begin
            ctrl_d    = '0;
            valid_d   = 1'b0;
            illegal_d = 1'b1;
        end else if (MEM_BUSYWAIT) begin
            state_d = ST_STALL;
        end else begin
            // Leaving STALL applies the RUN rules on the same edge.
            state_d = ST_RUN;
            if (FLUSH || !INSTR_VALID) begin
                ctrl_d  = '0;
                valid_d = 1'b0;
            end else if (!dec_illegal) begin
                ctrl_d  = dec_ctrl;
                valid_d = 1'b1;
                count_d = count_q + CNT_W'(1);
            end else begin
                ctrl_d    = '0;
                valid_d   = 1'b0;
                illegal_d = 1'b1;
                state_d   = ST_TRAP;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_RUN;
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign ALUOP       = ALUOP_W'(ctrl_q.aluop);
    assign WRITEENABLE = ctrl_q.write_enable;
    assign SUBMUXSEL   = ctrl_q.sub_mux_sel;
    assign IMMUXSEL    = ctrl_q.imm_mux_sel;
    assign JUMP        = ctrl_q.jump;
    assign BEQ         = ctrl_q.beq;
    assign BNE         = ctrl_q.bne;
    assign READ        = ctrl_q.read;
    assign WRITE       = ctrl_q.write;
    assign WRITESEL    = ctrl_q.write_sel;
    assign CTRL_VALID  = valid_q;
    assign ILLEGAL     = illegal_q;
    assign INSTR_COUNT = count_q;
    assign PC_HOLD     = MEM_BUSYWAIT | (state_q == ST_TRAP);

endmodule
